// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - I/O window address map shared by the CPU, io_bridge and the testbench
package io_map_pkg;

  localparam logic [31:0] IO_BASE = 32'hFFFF_F000;
  localparam logic [11:0] SEG_OFS = 12'h000;
  localparam logic [11:0] LED_OFS = 12'h060;
  localparam logic [11:0] SW_OFS  = 12'h070;

  typedef enum logic [2:0] {REG_DRAM, REG_SEG, REG_LED, REG_SW, REG_NONE} region_t;

  // Byte offsets [1:0] are ignored; only whole words inside the 4 KiB window are mapped.
  function automatic region_t decode_region(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] ofs;
    region_t     reg_hit;
    ofs = addr - base;
    if (addr < base) begin
      reg_hit = REG_DRAM;
    end else if (ofs[31:12] != 20'h0) begin
      reg_hit = REG_NONE;
    end else if (ofs[11:2] == SEG_OFS[11:2]) begin
      reg_hit = REG_SEG;
    end else if (ofs[11:2] == LED_OFS[11:2]) begin
      reg_hit = REG_LED;
    end else if (ofs[11:2] == SW_OFS[11:2]) begin
      reg_hit = REG_SW;
    end else begin
      reg_hit = REG_NONE;
    end
    return reg_hit;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus hold-time debounce for the board switches
module sw_debounce #(
  parameter int          WIDTH           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sw_sync;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
    end else begin
      sync_meta <= sw_in;
      sw_sync   <= sync_meta;
      // sync_meta != sw_sync means sw_sync changes at this edge, so the new value starts a fresh count
      if (sw_sync == sw_stable || sync_meta != sw_sync) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable <= sw_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - CPU data-port decode, LED/SEG registers, switch input and load mux
module io_bridge
  import io_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] BASE            = IO_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] dram_rd,
  input  logic [23:0] sw_in,
  output logic [31:0] rdata,
  output logic        dram_we,
  output logic [31:0] seg_data,
  output logic        seg_we,
  output logic [23:0] led_out
);

  region_t     region;
  logic [23:0] sw_stable;

  assign region  = decode_region(addr, BASE);
  assign dram_we = we && (region == REG_DRAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_data <= '0;
      seg_we   <= 1'b0;
      led_out  <= '0;
    end else begin
      seg_we <= we && (region == REG_SEG);
      if (we && region == REG_SEG) seg_data <= wdata;
      if (we && region == REG_LED) led_out  <= wdata[23:0];
    end
  end

  // SEG is write-only, so it reads back as zero like any unmapped slot
  always_comb begin
    rdata = '0;
    case (region)
      REG_DRAM: rdata = dram_rd;
      REG_LED:  rdata = {8'h0, led_out};
      REG_SW:   rdata = {8'h0, sw_stable};
      default:  rdata = '0;
    endcase
  end

  sw_debounce #(
    .WIDTH          (24),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .sw_stable(sw_stable)
  );

endmodule
